// File: rtl/lpc_frame_buffer.sv
// Purpose : circular sample buffer for one LPC analysis frame; lagged random-access reads.
// Latency : read data registered, rd_valid one cycle after rd_en; a write is visible to the next cycle's read.
// Backpres: wr_ready = !busy; writes offered while busy are dropped, rd_en is ignored while busy.
//
// Ports:
//   clk, reset        single rising-edge clock, synchronous active-low reset
//   wr_valid/wr_data  sample write, accepted when wr_valid && wr_ready
//   wr_ready          low only during the optional clear sweep
//   rd_en/rd_lag      read request, lag counted back from the newest sample (0 = newest)
//   rd_data/rd_valid  registered read result; rd_err flags a lag that is not yet filled
//   fill              stored-sample count, saturating at DEPTH
//   frame_done        one-cycle pulse after the write to the last buffer slot
//   busy              clear sweep in progress
//
// Build option: define LPC_FRAME_BUF_CLEAR_EN to zero the whole array after every reset
// (DEPTH cycles of busy). Without it the buffer is usable on the first cycle after reset.

module lpc_frame_buffer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 160,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_lag,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic [ADDR_W:0]   fill,
  output logic              frame_done,
  output logic              busy
);

  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t state;

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] newest;

  // Storage is deliberately not reset; fill guards every read of stale contents.
  logic [DATA_W-1:0] mem [0:DEPTH-1];

`ifdef LPC_FRAME_BUF_CLEAR_EN
  logic [ADDR_W-1:0] sweep_addr;
`endif

  logic              wr_fire;
  logic              rd_take;
  logic [ADDR_W:0]   lag_ext;
  logic [ADDR_W:0]   newest_ext;
  logic [ADDR_W:0]   raddr_ext;
  logic [ADDR_W-1:0] raddr;
  logic              lag_ok;
  logic              bypass;
  logic [ADDR_W-1:0] wptr_nxt;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign wr_ready = !busy;
  assign wr_fire  = wr_valid && wr_ready;
  assign rd_take  = rd_en && !busy;

  // Lag check and address use the pre-write fill/newest of this cycle.
  assign lag_ext    = {1'b0, rd_lag};
  assign newest_ext = {1'b0, newest};
  assign lag_ok     = (lag_ext < fill) && (lag_ext < DEPTH_V);

  // Modulo-DEPTH subtraction without assuming a power-of-two depth.
  assign raddr_ext = (newest_ext >= lag_ext) ? (newest_ext - lag_ext)
                                             : (newest_ext + DEPTH_V - lag_ext);
  assign raddr     = raddr_ext[ADDR_W-1:0];

  // Only reachable with a full buffer and the oldest lag: the slot being read is
  // overwritten this same cycle, and the new sample is returned.
  assign bypass    = wr_fire && (wptr == raddr);

  assign wptr_nxt  = (wptr == LAST) ? '0 : (wptr + ADDR_W'(1));

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wptr;
    mem_wdata = wr_data;
    if (reset && wr_fire) begin
      mem_we = 1'b1;
    end
`ifdef LPC_FRAME_BUF_CLEAR_EN
    if (reset && (state == ST_INIT)) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_addr;
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr       <= '0;
      newest     <= LAST;
      fill       <= '0;
      rd_valid   <= 1'b0;
      rd_err     <= 1'b0;
      rd_data    <= '0;
      frame_done <= 1'b0;
`ifdef LPC_FRAME_BUF_CLEAR_EN
      state      <= ST_INIT;
      busy       <= 1'b1;
      sweep_addr <= '0;
`else
      state      <= ST_RUN;
      busy       <= 1'b0;
`endif
    end else begin
      rd_valid   <= rd_take;
      rd_err     <= rd_take && !lag_ok;
      frame_done <= wr_fire && (wptr == LAST);

      if (rd_take) begin
        if (!lag_ok) begin
          rd_data <= '0;
        end else if (bypass) begin
          rd_data <= wr_data;
        end else begin
          rd_data <= mem[raddr];
        end
      end

      if (wr_fire) begin
        newest <= wptr;
        wptr   <= wptr_nxt;
        if (fill != DEPTH_V) begin
          fill <= fill + (ADDR_W+1)'(1);
        end
      end

      case (state)
        ST_INIT: begin
`ifdef LPC_FRAME_BUF_CLEAR_EN
          sweep_addr <= sweep_addr + ADDR_W'(1);
          if (sweep_addr == LAST) begin
            state <= ST_RUN;
            busy  <= 1'b0;
          end
`else
          state <= ST_RUN;
          busy  <= 1'b0;
`endif
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_frame_buffer.sv
// Purpose : directed self-checking bench for lpc_frame_buffer with a read scoreboard.
// Latency : expects read results one cycle after rd_en, frame_done one cycle after the last-slot write.
// Backpres: drives writes only while wr_ready is high, except during the clear sweep where drops are probed.

module tb_lpc_frame_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 160;
  localparam int ADDR_W = 8;

  logic              clk;
  logic              reset;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_lag;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_err;
  logic [ADDR_W:0]   fill;
  logic              frame_done;
  logic              busy;

  lpc_frame_buffer #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_en     (rd_en),
    .rd_lag    (rd_lag),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_err    (rd_err),
    .fill      (fill),
    .frame_done(frame_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              err;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] model_mem [DEPTH];
  int                m_wptr;
  int                m_fill;
  int                passed;
  int                total;
  int                fd_count;
  logic [DATA_W-1:0] last_data;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // One clock of stimulus; read expectations use the buffer state before this cycle's write.
  task automatic step(input logic wv, input logic [DATA_W-1:0] wd,
                      input logic re, input logic [ADDR_W-1:0] lag);
    exp_t e;
    logic exp_fd;
    int   nw;
    int   a;
    wr_valid = wv;
    wr_data  = wd;
    rd_en    = re;
    rd_lag   = lag;
    if (re) begin
      nw = (m_wptr + DEPTH - 1) % DEPTH;
      if (int'(lag) >= m_fill) begin
        e.err  = 1'b1;
        e.data = '0;
      end else begin
        a      = (nw - int'(lag) + DEPTH) % DEPTH;
        e.err  = 1'b0;
        // The oldest slot being overwritten this cycle returns the incoming sample.
        e.data = (wv && (a == m_wptr)) ? wd : model_mem[a];
      end
      sb.push_back(e);
    end
    exp_fd = wv && (m_wptr == DEPTH - 1);
    @(posedge clk);
    if (wv) begin
      model_mem[m_wptr] = wd;
      m_wptr = (m_wptr + 1) % DEPTH;
      if (m_fill < DEPTH) m_fill++;
    end
    #1;
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    check("rd_valid", 32'(rd_valid), 32'(re));
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    check("fill", 32'(fill), 32'(m_fill));
    if (frame_done === 1'b1) fd_count++;
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rd", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("rd_err", 32'(rd_err), 32'(e.err));
        check("rd_data", 32'(rd_data), 32'(e.data));
        last_data = e.data;
      end
    end else begin
      check("rd_err_idle", 32'(rd_err), 32'd0);
      check("rd_data_hold", 32'(rd_data), 32'(last_data));
    end
  endtask

  task automatic wr(input int v);
    step(1'b1, DATA_W'(v), 1'b0, '0);
  endtask

  task automatic rd(input int lag);
    step(1'b0, '0, 1'b1, ADDR_W'(lag));
  endtask

  task automatic do_reset();
`ifdef LPC_FRAME_BUF_CLEAR_EN
    int   busy_cycles;
    logic quiet;
`endif
    reset    = 1'b0;
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    @(posedge clk);
    #1;
    reset     = 1'b1;
    m_wptr    = 0;
    m_fill    = 0;
    last_data = '0;
    fd_count  = 0;
    sb.delete();
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_err", 32'(rd_err), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
`ifdef LPC_FRAME_BUF_CLEAR_EN
    busy_cycles = 0;
    quiet       = 1'b1;
    // Offer writes and reads throughout the sweep; all must be ignored.
    while (busy === 1'b1 && busy_cycles < 4 * DEPTH) begin
      if (wr_ready !== 1'b0 || rd_valid !== 1'b0) quiet = 1'b0;
      busy_cycles++;
      wr_valid = 1'b1;
      wr_data  = 16'hDEAD;
      rd_en    = 1'b1;
      rd_lag   = '0;
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    check("busy_cycles", 32'(busy_cycles), 32'(DEPTH));
    check("init_quiet", 32'(quiet), 32'd1);
    check("init_fill", 32'(fill), 32'd0);
    check("init_rd_valid", 32'(rd_valid), 32'd0);
`else
    check("busy", 32'(busy), 32'd0);
`endif
    check("wr_ready", 32'(wr_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_en    = 1'b0;
    rd_lag   = '0;
    passed   = 0;
    total    = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // Empty buffer: every lag is unfilled.
    rd(0);

    // Partial fill: lag equal to fill is an error, fill-1 is the first sample.
    for (int v = 1; v <= 3; v++) wr(v);
    rd(3);
    rd(2);
    rd(0);

    // Complete the first frame; exactly one frame_done pulse.
    for (int v = 4; v <= DEPTH; v++) wr(v);
    check("frame_pulses", 32'(fd_count), 32'd1);
    check("full_fill", 32'(fill), 32'(DEPTH));
    rd(0);
    check("lag0_full", 32'(rd_data), 32'd160);
    rd(DEPTH - 1);
    check("lag159_full", 32'(rd_data), 32'd1);

    // Wrap: oldest samples overwritten, fill holds at DEPTH.
    for (int v = DEPTH + 1; v <= 165; v++) wr(v);
    rd(0);
    check("lag0_wrap", 32'(rd_data), 32'd165);
    rd(DEPTH - 1);
    check("lag159_wrap", 32'(rd_data), 32'd6);
    rd(200);
    step(1'b0, '0, 1'b0, '0);

    // Same-cycle write to the oldest slot while reading it.
    step(1'b1, 16'hBEEF, 1'b1, ADDR_W'(DEPTH - 1));
    check("bypass_beef", 32'(rd_data), 32'hBEEF);
    rd(0);
    // Lag 0 with a concurrent write returns the pre-write newest sample.
    step(1'b1, 16'h1234, 1'b1, '0);
    check("lag0_prewrite", 32'(rd_data), 32'hBEEF);
    rd(0);

    // Reset mid-frame hides everything written before it.
    do_reset();
    for (int v = 1; v <= 50; v++) wr(v + 1000);
    do_reset();
    rd(0);
    check("post_rst_err", 32'(rd_err), 32'd1);
    wr(16'h0A0A);
    wr(16'h0B0B);
    rd(0);
    rd(1);
    check("post_rst_lag1", 32'(rd_data), 32'h0A0A);
    rd(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
